acumulador_ula: RTL
===================

Name: acumulador_ula

Overview:
- SAP-1 accumulator (register A) plus adder/subtractor (ULA).
- Sits directly downstream of registradorB and consumes its para_ula output as operand B.
- Loads A from the W bus, computes A+B or A−B, and drives A or the result back onto the bus under control-word signals.
- Keeps registered status flags and a sticky bus-conflict error.

Parameters:
- LARGURA, 8, data width of A, B, bus and result.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- La  input  1  load A from entrada_barramento on rising CLK.
- Ea  input  1  drive A onto saida_barramento.
- Su  input  1  0 = add, 1 = subtract (A − B).
- Eu  input  1  drive ULA result onto saida_barramento.
- Lf  input  1  capture flags from current ULA result on rising CLK.
- entrada_barramento  input  LARGURA  W bus value.
- para_ula  input  LARGURA  operand B from registradorB.
- saida_barramento  output  LARGURA  value this block drives to the bus.
- barramento_ativo  output  1  high when Ea or Eu is asserted.
- acumulador  output  LARGURA  current A contents, for display/debug.
- flag_zero  output  1  registered: result == 0.
- flag_carry  output  1  registered: carry out (subtract: 1 = no borrow).
- flag_neg  output  1  registered: result MSB.
- erro_conflito  output  1  sticky: Ea and Eu were asserted together.

Behaviour:
- Reset (CLR=1, asynchronous):
  - A = 0; flags = 0; erro_conflito = 0.
  - Outputs settle to: saida_barramento = 0 unless Ea/Eu are asserted; acumulador = 0.
  - Reset mid-operation overrides any La/Lf on the same edge.
- Register A:
  - On rising CLK with La=1, A <= entrada_barramento.
  - With La=0, A holds.
  - acumulador = A at all times.
- ULA arithmetic is combinational and (LARGURA+1) bits wide:
  - Su=0: soma = {0,A} + {0,B}.
  - Su=1: soma = {0,A} + {0,~B} + 1 (two's complement).
  - resultado = soma[LARGURA−1:0]; carry = soma[LARGURA].
  - Wrap-around modulo 2^LARGURA; no saturation.
- Bus drive:
  - Eu=1: saida_barramento = resultado.
  - Ea=1 and Eu=0: saida_barramento = A.
  - Neither asserted: saida_barramento = 0, so the bus can be OR-combined.
  - Eu has priority when both are asserted.
  - barramento_ativo = Ea | Eu.
- Conflict:
  - Rising CLK with Ea=1 and Eu=1 sets erro_conflito = 1.
  - Cleared only by CLR.
- Flags:
  - On rising CLK with Lf=1, flags capture carry, (resultado==0) and resultado[MSB], evaluated from the pre-edge A.
  - With Lf=0, flags hold.
- Simultaneous La and Lf:
  - Flags reflect the old A.
  - The new A is visible from the next cycle.
- La with Eu on the same edge (ADD/SUB "A <= A op B" step, with the bus looped externally): A captures entrada_barramento, which equals the pre-edge result.
- Latency:
  - Result and bus output are combinational, zero cycles.
  - A update is 1 cycle.
  - Flags are 1 cycle.

Optional Feature:
- Macro: SAP1_ULA_PIPE_EN.
- Defined:
  - A result register captures resultado and carry on every rising CLK; CLR clears it to 0.
  - Eu drives the registered result.
  - Lf samples flags from the registered result and carry.
  - Effective latency from A/B/Su change to bus is 1 cycle; control must wait one cycle before Eu.
- Undefined:
  - Purely combinational result path as described above.
  - No extra register.

Test Plan:
- Reset: assert CLR asynchronously mid-cycle with A=0x5A and flags set → A, acumulador and all flags read 0 immediately, without waiting for a CLK edge; erro_conflito = 0.
- Add: La with bus=0x14, B=0x0A, Su=0, Eu=1, Lf=1 → saida_barramento = 0x1E; after the edge flag_carry=0, flag_zero=0, flag_neg=0.
- Subtract to zero: A=0x0F, B=0x0F, Su=1, Eu=1, Lf=1 → saida_barramento = 0x00; flags zero=1, carry=1, neg=0.
- Wrap/borrow and overflow:
  - A=0x05, B=0x07, Su=1 → result = 0xFE; carry=0, neg=1.
  - A=0xFF, B=0x02, Su=0 → result = 0x01; carry=1.
- Bus control:
  - Ea=1, Eu=0 with A=0x33 → bus = 0x33, barramento_ativo=1.
  - Both low → bus = 0x00, barramento_ativo=0.
  - Ea=Eu=1 over one edge → bus = resultado; erro_conflito=1 and stays set until CLR.
- Pipeline (SAP1_ULA_PIPE_EN defined): change B from 0x01 to 0x02 with A=0x10, Su=0, Eu=1 → bus shows 0x11 until the next rising edge, then 0x12.

Source files
------------

// File: rtl/acumulador_ula.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : acumulador_ula                                              |
// | Brief    : SAP-1 accumulator (A) with adder/subtractor, bus drive,     |
// |            registered status flags and sticky bus-conflict error.      |
// |            Optional macro SAP1_ULA_PIPE_EN registers the ULA result.   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module acumulador_ula #(
  parameter int LARGURA = 8
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               La,
  input  logic               Ea,
  input  logic               Su,
  input  logic               Eu,
  input  logic               Lf,
  input  logic [LARGURA-1:0] entrada_barramento,
  input  logic [LARGURA-1:0] para_ula,
  output logic [LARGURA-1:0] saida_barramento,
  output logic               barramento_ativo,
  output logic [LARGURA-1:0] acumulador,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               flag_neg,
  output logic               erro_conflito
);

  logic [LARGURA-1:0] reg_a;
  logic [LARGURA-1:0] operando_b;
  logic [LARGURA:0]   soma;
  logic [LARGURA-1:0] resultado;
  logic               carry;
  logic [LARGURA-1:0] resultado_sel;
  logic               carry_sel;

  // Subtraction is A + ~B + 1; the carry-in is simply Su.
  assign operando_b = Su ? ~para_ula : para_ula;
  assign soma       = {1'b0, reg_a} + {1'b0, operando_b} + {{LARGURA{1'b0}}, Su};
  assign resultado  = soma[LARGURA-1:0];
  assign carry      = soma[LARGURA];

`ifdef SAP1_ULA_PIPE_EN
  logic [LARGURA-1:0] reg_resultado;
  logic               reg_carry;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      reg_resultado <= '0;
      reg_carry     <= 1'b0;
    end else begin
      reg_resultado <= resultado;
      reg_carry     <= carry;
    end
  end

  assign resultado_sel = reg_resultado;
  assign carry_sel     = reg_carry;
`else
  assign resultado_sel = resultado;
  assign carry_sel     = carry;
`endif

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      reg_a <= '0;
    end else if (La) begin
      reg_a <= entrada_barramento;
    end
  end

  // Flags sample the result computed from the pre-edge A.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_neg   <= 1'b0;
    end else if (Lf) begin
      flag_zero  <= (resultado_sel == '0);
      flag_carry <= carry_sel;
      flag_neg   <= resultado_sel[LARGURA-1];
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      erro_conflito <= 1'b0;
    end else if (Ea && Eu) begin
      erro_conflito <= 1'b1;
    end
  end

  // Idle output is zero so several drivers can be OR-combined onto the bus.
  always_comb begin
    saida_barramento = '0;
    if (Eu) begin
      saida_barramento = resultado_sel;
    end else if (Ea) begin
      saida_barramento = reg_a;
    end
  end

  assign barramento_ativo = Ea | Eu;
  assign acumulador       = reg_a;

endmodule
`default_nettype wire
